// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Memory-side responder for the MEM stage. One 32-bit load or store is
// carried out as two half-word accesses on a 16-bit asynchronous SRAM: the
// low half-word at the even SRAM address, then the high half-word at the odd
// address (little-endian). While an access is in progress `ready` is held low
// so the pipeline freeze keeps the request stable. `ready` returns high for
// exactly one cycle (DONE) when the access retires.
//
// Parameters
//   ACCESS_CYCLES : cycles per half-word access, legal range 2..7
//   BASE_ADDR     : CPU byte address mapped to SRAM word 0
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous reset, active low
//   rd_en        in   load request
//   wr_en        in   store request (wins when both are set)
//   address      in   CPU byte address [31:0]
//   write_data   in   store value [31:0]
//   read_data    out  load result [31:0], valid while ready=1 in DONE
//   ready        out  0 = freeze the pipeline, 1 = retire / nothing pending
//   sram_addr    out  SRAM half-word address [17:0]
//   sram_dq_out  out  data driven to the SRAM [15:0]
//   sram_dq_in   in   data read from the SRAM [15:0]
//   sram_dq_oe   out  1 = drive sram_dq_out onto the bus
//   sram_we_n    out  write enable, active low
//   sram_ce_n    out  chip enable, tied active
//   sram_oe_n    out  output enable, tied active
//   sram_ub_n    out  upper byte lane, tied active
//   sram_lb_n    out  lower byte lane, tied active
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter int          ACCESS_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last value of the per-phase counter; the phase ends on this count.
  localparam logic [2:0] CNT_LAST = 3'(ACCESS_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [2:0]  cnt;
  logic        req;
  logic        last;
  logic [31:0] offs;
  logic [16:0] req_word;
  logic        unused_offs;

  // Request fields captured when leaving IDLE; the pipeline holds its
  // request stable anyway, but latching decouples the SRAM pins from it.
  logic        is_wr_p1;
  logic [16:0] word_p1;
  logic [31:0] wdata_p1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [17:0] half_addr(input logic [16:0] word,
                                            input logic        upper);
    return {word, upper};
  endfunction

  function automatic logic [15:0] data_half(input logic [31:0] data,
                                            input logic        upper);
    return upper ? data[31:16] : data[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode and address map (stage p0: live MEM-stage inputs)
  // ---------------------------------------------------------------------------
  assign req      = rd_en | wr_en;
  assign offs     = address - BASE_ADDR;
  assign req_word = offs[18:2];
  // Byte offset within the word and the bits above the SRAM range are
  // deliberately discarded.
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  assign last = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req)  next_state = LOW;
      LOW:  if (last) next_state = HIGH;
      HIGH: if (last) next_state = DONE;
      // The pipeline advances on the DONE edge, so anything still requesting
      // in the following IDLE cycle is a new instruction.
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Phase counter, request latch and read capture (stage p1)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= 3'd0;
      is_wr_p1  <= 1'b0;
      word_p1   <= 17'd0;
      wdata_p1  <= 32'd0;
      read_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (req) begin
            is_wr_p1 <= wr_en;
            word_p1  <= req_word;
            wdata_p1 <= write_data;
          end
        end
        LOW, HIGH: begin
          cnt <= last ? 3'd0 : cnt + 3'd1;
          // Sample the bus at the very end of the phase, after the full
          // access time has elapsed.
          if (!is_wr_p1 && last) begin
            if (state == LOW) begin
              read_data[15:0] <= sram_dq_in;
            end else begin
              read_data[31:16] <= sram_dq_in;
            end
          end
        end
        default: begin
          cnt <= 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        // Combinational so the freeze asserts in the request's own cycle.
        ready = ~req;
      end
      LOW, HIGH: begin
        sram_addr = half_addr(word_p1, state == HIGH);
        if (is_wr_p1) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = data_half(wdata_p1, state == HIGH);
          // WE rises one cycle before the phase ends so address and data
          // stay stable across the rising edge that commits the write.
          sram_we_n   = last;
        end
      end
      DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Directed bench for sram_controller with a behavioural 16-bit SRAM. Expected
// load results come from a word-level reference map kept by the bench; they
// are queued when a request is driven and compared when the DUT retires it.
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam int AC  = 3;
  localparam int LAT = 2 * AC + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] ref_words [int];
  logic [31:0] last_read = 32'h0;

  always #5 clk = ~clk;

  sram_controller #(
    .ACCESS_CYCLES(AC),
    .BASE_ADDR    (32'd1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  // Behavioural SRAM: asynchronous read, write committed while WE is low.
  logic [15:0] mem [0:262143];
  assign sram_dq_in = mem[sram_addr];

  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr] <= sram_dq_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drop the request and check the idle bus one cycle later.
  task automatic idle_cycle(input string tag);
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_idle_we_n"}, {31'd0, sram_we_n}, 32'd1);
    check({tag, "_idle_oe"}, {31'd0, sram_dq_oe}, 32'd0);
    check({tag, "_idle_addr"}, {14'd0, sram_addr}, 32'd0);
  endtask

  // One transaction. Called at a negedge; with b2b=1 that negedge is the
  // DONE cycle of the previous transaction, otherwise it is an IDLE cycle.
  task automatic txn(input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input bit b2b,
                     input string tag);
    int cyc;
    int wen;
    int oen;
    int w;
    logic [31:0] exp;
    w = int'((addr - 32'd1024) >> 2);
    if (wr) begin
      ref_words[w] = data;
      exp_q.push_back(last_read);
    end else begin
      exp = ref_words.exists(w) ? ref_words[w] : 32'h0;
      last_read = exp;
      exp_q.push_back(exp);
    end
    wr_en      = wr;
    rd_en      = !wr;
    address    = addr;
    write_data = data;
    #1;
    if (b2b) begin
      check({tag, "_prev_done_ready"}, {31'd0, ready}, 32'd1);
      @(negedge clk);
    end
    cyc = 1;
    wen = sram_we_n ? 0 : 1;
    oen = sram_dq_oe ? 1 : 0;
    check({tag, "_freeze_start"}, {31'd0, ready}, 32'd0);
    while (ready !== 1'b1 && cyc < 4 * LAT) begin
      @(negedge clk);
      cyc++;
      if (!sram_we_n) wen++;
      if (sram_dq_oe) oen++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT));
    exp = exp_q.pop_front();
    check({tag, "_read_data"}, read_data, exp);
    check({tag, "_we_low_cycles"}, 32'(wen), wr ? 32'(2 * (AC - 1)) : 32'd0);
    check({tag, "_oe_cycles"}, 32'(oen), wr ? 32'(2 * AC) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("tied_pins", {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n},
          32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Write then read back at the base address
    txn(1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, "wr_base");
    check("mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check("mem1", {16'd0, mem[1]}, 32'h0000DEAD);
    idle_cycle("after_wr_base");
    txn(1'b0, 32'd1024, 32'h0, 1'b0, "rd_base");
    idle_cycle("after_rd_base");

    // Address map, low address bits ignored
    txn(1'b1, 32'd1036, 32'h12345678, 1'b0, "wr_1036");
    check("mem6", {16'd0, mem[6]}, 32'h00005678);
    check("mem7", {16'd0, mem[7]}, 32'h00001234);
    idle_cycle("after_wr_1036");
    txn(1'b0, 32'd1037, 32'h0, 1'b0, "rd_1037");
    idle_cycle("after_rd_1037");

    // Back-to-back store and load with the request held continuously
    txn(1'b1, 32'd1028, 32'hCAFEF00D, 1'b0, "b2b_wr");
    txn(1'b0, 32'd1028, 32'h0, 1'b1, "b2b_rd");
    check("mem2", {16'd0, mem[2]}, 32'h0000F00D);
    check("mem3", {16'd0, mem[3]}, 32'h0000CAFE);
    idle_cycle("after_b2b");

    // Reset during the HIGH phase of a read
    rd_en   = 1'b1;
    wr_en   = 1'b0;
    address = 32'd1024;
    repeat (4) @(negedge clk);
    check("abort_low_captured", read_data, 32'hCAFEBEEF);
    check("abort_in_high", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_read_data", read_data, 32'd0);
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_addr", {14'd0, sram_addr}, 32'd0);
    check("abort_idle_req_ready", {31'd0, ready}, 32'd0);
    rst   = 1'b1;
    rd_en = 1'b0;
    #1;
    check("abort_idle_noreq_ready", {31'd0, ready}, 32'd1);
    last_read = 32'h0;
    @(negedge clk);
    txn(1'b0, 32'd1024, 32'h0, 1'b0, "rd_after_abort");
    idle_cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
